cram_ctrl: RTL and testbench
============================

# cram_ctrl

Synchronous initiator for the external 512x8 asynchronous colour SRAMs on the K051962 board. It arbitrates between a video fetch port and a CPU port and produces SRAM address, chip-enable, output-enable and write-enable strobes with programmable strobe width. It also captures read data. The block sits between the tilemap pipeline/CPU interface and the SRAM pins; the top level joins SRAM_DOUT, SRAM_DIN and SRAM_DOE into the bidirectional DATA bus.

## Interface
- WAIT_CYC, 2, clocks OEn/WEn held low per access; legal 1..8
- CLK  in  1  system clock, all state on rising edge
- RESETn  in  1  asynchronous, active-low reset
- VID_REQ  in  1  video read request, level, held until VID_ACK
- VID_ADDR  in  9  video read address
- VID_ACK  out  1  one-cycle pulse, VID_DATA valid
- VID_DATA  out  8  captured read data, held until next video ACK
- CPU_REQ  in  1  CPU request, level, held until CPU_ACK
- CPU_WE  in  1  1 = write, 0 = read
- CPU_ADDR  in  9  CPU address
- CPU_WDATA  in  8  write data
- CPU_ACK  out  1  one-cycle pulse, completion
- CPU_RDATA  out  8  captured read data, held until next CPU read ACK
- SRAM_ADDR  out  9  SRAM address
- SRAM_CEn / SRAM_OEn / SRAM_WEn  out  1 each  active-low strobes
- SRAM_DOUT  out  8  write data; SRAM_DOE  out  1  drive enable
- SRAM_DIN  in  8  data from SRAM
- ERR  out  1  sticky readback mismatch (see Configuration)

## Operation
- FSM states: IDLE, SETUP, STROBE, HOLD (plus RB_SETUP, RB_STROBE, RB_HOLD under macro).
- IDLE: sample requests, grant, latch address, data and direction into registers. SRAM_CEn=1. Go to SETUP if either REQ is high.
- SETUP, 1 cycle: SRAM_ADDR stable, CEn=0, OEn=WEn=1. DOE=1 for writes.
- STROBE, WAIT_CYC cycles: counter 3 bits. Reads drive OEn=0; writes drive WEn=0. SRAM_DIN is captured on the last STROBE cycle.
- HOLD, 1 cycle: OEn=WEn=1, CEn=0, DOE still 1 for writes. The granted port's ACK=1 and its data register is updated. Then go to IDLE.
- Arbitration: video has priority. A starvation counter counts consecutive CPU losses; after 2 losses the CPU wins the next grant. The counter clears on CPU grant.
- Requesters drop REQ at the edge after seeing ACK. Any REQ seen in IDLE is treated as new.
- Reads never assert DOE. A write's DOE rises no earlier than 2 cycles after a preceding read's OEn deassert, which gives bus turnaround through HOLD→IDLE.

## Timing
- Reset values: SRAM_CEn/OEn/WEn=1, DOE=0, SRAM_ADDR=0, SRAM_DOUT=0, ACKs=0, VID_DATA=CPU_RDATA=0, ERR=0, state IDLE, starvation counter 0.
- Latency: the request is sampled at IDLE cycle 0. ACK is asserted in cycle 2+WAIT_CYC. The minimum issue period is 3+WAIT_CYC.
- WEn low window is strictly inside the CEn-low and DOE-high window, with ≥1 cycle of address/data setup and hold.
- Simultaneous VID_REQ and CPU_REQ: video is granted unless the starvation count is 2.
- Reset asserted mid-access: strobes go inactive immediately (asynchronously), the transaction is discarded and no ACK is issued.

## Configuration
- CRAM_CTRL_READBACK_EN defined: each CPU write continues HOLD→RB_SETUP→RB_STROBE (WAIT_CYC)→RB_HOLD as a read of the same address, with DOE=0.
  - CPU_ACK is issued in RB_HOLD, giving write latency 4+2·WAIT_CYC.
  - A mismatch against CPU_WDATA sets ERR, which clears only on reset.
- Undefined: writes end at HOLD and ERR is tied 0.

## Structure
- Package cram_ctrl_pkg holds:
  - the state enum;
  - CRAM_ADDR_W=9 and CRAM_DATA_W=8;
  - STARVE_LIMIT=2.
- Sub-module cram_arb is the two-port priority arbiter with the starvation counter. It outputs grant_vid and grant_cpu on the IDLE cycle.

## Test plan
- Reset, RESETn low 5 cycles: CEn/OEn/WEn=1, DOE=0, ACKs=0, ERR=0 throughout and in the first cycle after release.
- WAIT_CYC=2, CPU write 0x1A5←0x3C:
  - WEn low in cycles 2–3, DOE high in cycles 1–4, CPU_ACK in cycle 4;
  - a following CPU read of 0x1A5 returns CPU_RDATA=0x3C with ACK in cycle 4.
- VID_REQ and CPU_REQ held continuously: grant order V,V,C,V,V,C; each ACK targets only the granted port.
- RESETn pulsed low during STROBE of a write: WEn=1 within the same cycle, no CPU_ACK, state IDLE after release, and a retried write completes normally.
- With CRAM_CTRL_READBACK_EN and the SRAM model forcing bit 0 low, write 0x01 to 0x010: CPU_ACK in cycle 8 and ERR=1 stays high. Without the macro: ACK in cycle 4 and ERR=0.
- WAIT_CYC=1 and 8, video read: ACK in cycles 3 and 10 respectively, and OEn is low for exactly 1 and 8 cycles.

Source files
------------

// File: rtl/cram_ctrl_pkg.sv
// Shared types and sizes for the colour-RAM controller.
// The readback states exist only when CRAM_CTRL_READBACK_EN is defined.
package cram_ctrl_pkg;

   localparam int CRAM_ADDR_W  = 9;
   localparam int CRAM_DATA_W  = 8;
   localparam int STARVE_LIMIT = 2;

`ifdef CRAM_CTRL_READBACK_EN
   typedef enum logic [2:0] {
      IDLE, SETUP, STROBE, HOLD, RB_SETUP, RB_STROBE, RB_HOLD
   } state_t;
`else
   typedef enum logic [1:0] {
      IDLE, SETUP, STROBE, HOLD
   } state_t;
`endif

   typedef struct packed {
      logic                   we;
      logic [CRAM_ADDR_W-1:0] addr;
      logic [CRAM_DATA_W-1:0] wdata;
   } cram_req_t;

endpackage

// File: rtl/cram_arb.sv
// Video-priority two-port arbiter; the CPU wins after STARVE_LIMIT consecutive losses.
// Grants are combinational and only meaningful while sample is high (controller IDLE).
module cram_arb
   import cram_ctrl_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic sample,
   input  logic vid_req,
   input  logic cpu_req,
   output logic grant_vid,
   output logic grant_cpu
);

   localparam int SW = $clog2(STARVE_LIMIT + 1);

   logic [SW-1:0] starve;
   logic          starved;

   assign starved = (starve >= SW'(STARVE_LIMIT));

   always_comb begin
      grant_vid = 1'b0;
      grant_cpu = 1'b0;
      if (sample) begin
         if (cpu_req && (!vid_req || starved))
            grant_cpu = 1'b1;
         else if (vid_req)
            grant_vid = 1'b1;
      end
   end

   // a loss is a video grant while the CPU was also asking
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         starve <= '0;
      else if (grant_cpu)
         starve <= '0;
      else if (grant_vid && cpu_req && !starved)
         starve <= starve + SW'(1);
   end

endmodule

// File: rtl/cram_ctrl.sv
// Synchronous initiator for the 512x8 asynchronous colour SRAM: video/CPU arbitration,
// strobe generation and read capture. Define CRAM_CTRL_READBACK_EN for CPU write verify.
module cram_ctrl
   import cram_ctrl_pkg::*;
#(
   parameter int WAIT_CYC = 2
) (
   input  logic                   CLK,
   input  logic                   RESETn,
   input  logic                   VID_REQ,
   input  logic [CRAM_ADDR_W-1:0] VID_ADDR,
   output logic                   VID_ACK,
   output logic [CRAM_DATA_W-1:0] VID_DATA,
   input  logic                   CPU_REQ,
   input  logic                   CPU_WE,
   input  logic [CRAM_ADDR_W-1:0] CPU_ADDR,
   input  logic [CRAM_DATA_W-1:0] CPU_WDATA,
   output logic                   CPU_ACK,
   output logic [CRAM_DATA_W-1:0] CPU_RDATA,
   output logic [CRAM_ADDR_W-1:0] SRAM_ADDR,
   output logic                   SRAM_CEn,
   output logic                   SRAM_OEn,
   output logic                   SRAM_WEn,
   output logic [CRAM_DATA_W-1:0] SRAM_DOUT,
   output logic                   SRAM_DOE,
   input  logic [CRAM_DATA_W-1:0] SRAM_DIN,
   output logic                   ERR
);

   localparam logic [2:0] CNT_LAST = 3'(WAIT_CYC - 1);

   state_t    state, state_nxt;
   cram_req_t req_q;
   logic      cpu_sel;
   logic [2:0] cnt;
   logic      cnt_last;
   logic      strobe;
   logic      idle;
   logic      grant_vid, grant_cpu;

   assign idle     = (state == IDLE);
   assign cnt_last = (cnt == CNT_LAST);
`ifdef CRAM_CTRL_READBACK_EN
   assign strobe   = (state == STROBE) || (state == RB_STROBE);
`else
   assign strobe   = (state == STROBE);
`endif

   cram_arb u_arb (
      .clk      (CLK),
      .rst_n    (RESETn),
      .sample   (idle),
      .vid_req  (VID_REQ),
      .cpu_req  (CPU_REQ),
      .grant_vid(grant_vid),
      .grant_cpu(grant_cpu)
   );

   // strobes decode straight from the async-reset state so reset kills them at once
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      SRAM_CEn  = 1'b1;
      SRAM_OEn  = 1'b1;
      SRAM_WEn  = 1'b1;
      SRAM_DOE  = 1'b0;
      VID_ACK   = 1'b0;
      CPU_ACK   = 1'b0;
      case (state)
         IDLE: begin
            if (VID_REQ || CPU_REQ)
               state_nxt = SETUP;
         end
         SETUP: begin
            SRAM_CEn  = 1'b0;
            SRAM_DOE  = req_q.we;
            state_nxt = STROBE;
         end
         STROBE: begin
            SRAM_CEn = 1'b0;
            SRAM_DOE = req_q.we;
            SRAM_OEn = req_q.we;
            SRAM_WEn = !req_q.we;
            if (cnt_last)
               state_nxt = HOLD;
         end
         HOLD: begin
            SRAM_CEn  = 1'b0;
            SRAM_DOE  = req_q.we;
            VID_ACK   = !cpu_sel;
            CPU_ACK   = cpu_sel;
            state_nxt = IDLE;
`ifdef CRAM_CTRL_READBACK_EN
            if (cpu_sel && req_q.we) begin
               CPU_ACK   = 1'b0;
               state_nxt = RB_SETUP;
            end
`endif
         end
`ifdef CRAM_CTRL_READBACK_EN
         RB_SETUP: begin
            SRAM_CEn  = 1'b0;
            state_nxt = RB_STROBE;
         end
         RB_STROBE: begin
            SRAM_CEn = 1'b0;
            SRAM_OEn = 1'b0;
            if (cnt_last)
               state_nxt = RB_HOLD;
         end
         RB_HOLD: begin
            SRAM_CEn  = 1'b0;
            CPU_ACK   = 1'b1;
            state_nxt = IDLE;
         end
`endif
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         req_q     <= '0;
         cpu_sel   <= 1'b0;
         cnt       <= 3'd0;
         VID_DATA  <= '0;
         CPU_RDATA <= '0;
      end else begin
         if (grant_cpu) begin
            req_q   <= '{we: CPU_WE, addr: CPU_ADDR, wdata: CPU_WDATA};
            cpu_sel <= 1'b1;
         end else if (grant_vid) begin
            req_q.we   <= 1'b0;
            req_q.addr <= VID_ADDR;
            cpu_sel    <= 1'b0;
         end
         if (strobe)
            cnt <= cnt_last ? 3'd0 : cnt + 3'd1;
         // read data lands in the port register so it is valid alongside ACK in HOLD
         if (state == STROBE && cnt_last && !req_q.we) begin
            if (cpu_sel)
               CPU_RDATA <= SRAM_DIN;
            else
               VID_DATA  <= SRAM_DIN;
         end
      end
   end

`ifdef CRAM_CTRL_READBACK_EN
   logic err_q;

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn)
         err_q <= 1'b0;
      else if (state == RB_STROBE && cnt_last && SRAM_DIN != req_q.wdata)
         err_q <= 1'b1;
   end

   assign ERR = err_q;
`else
   assign ERR = 1'b0;
`endif

   assign SRAM_ADDR = req_q.addr;
   assign SRAM_DOUT = req_q.wdata;

endmodule

// File: tb/tb_cram_ctrl.sv
// Randomised scoreboard bench for cram_ctrl: SRAM model, reference model, pin protocol monitor.
// Expectations follow CRAM_CTRL_READBACK_EN when it is defined for the build.
module tb_cram_ctrl;

   localparam int W = 2;
`ifdef CRAM_CTRL_READBACK_EN
   localparam bit RB = 1'b1;
`else
   localparam bit RB = 1'b0;
`endif

   logic       CLK = 1'b0;
   logic       RESETn = 1'b0;
   logic       VID_REQ = 1'b0, CPU_REQ = 1'b0, CPU_WE = 1'b0;
   logic [8:0] VID_ADDR = '0, CPU_ADDR = '0;
   logic [7:0] CPU_WDATA = '0;
   logic       VID_ACK, CPU_ACK, SRAM_CEn, SRAM_OEn, SRAM_WEn, SRAM_DOE, ERR;
   logic [7:0] VID_DATA, CPU_RDATA, SRAM_DOUT, SRAM_DIN;
   logic [8:0] SRAM_ADDR;

   always #5 CLK = ~CLK;

   cram_ctrl #(.WAIT_CYC(W)) dut (
      .CLK(CLK), .RESETn(RESETn),
      .VID_REQ(VID_REQ), .VID_ADDR(VID_ADDR), .VID_ACK(VID_ACK), .VID_DATA(VID_DATA),
      .CPU_REQ(CPU_REQ), .CPU_WE(CPU_WE), .CPU_ADDR(CPU_ADDR), .CPU_WDATA(CPU_WDATA),
      .CPU_ACK(CPU_ACK), .CPU_RDATA(CPU_RDATA),
      .SRAM_ADDR(SRAM_ADDR), .SRAM_CEn(SRAM_CEn), .SRAM_OEn(SRAM_OEn), .SRAM_WEn(SRAM_WEn),
      .SRAM_DOUT(SRAM_DOUT), .SRAM_DOE(SRAM_DOE), .SRAM_DIN(SRAM_DIN), .ERR(ERR)
   );

   // extra instances exercising the WAIT_CYC extremes with a fixed-pattern SRAM
   logic [1:0] x_vreq = '0;
   logic [1:0] x_vack, x_cack, x_cen, x_oen, x_wen, x_doe, x_err;
   logic [8:0] x_vaddr [2];
   logic [8:0] x_saddr [2];
   logic [7:0] x_vdata [2];
   logic [7:0] x_crd   [2];
   logic [7:0] x_dout  [2];
   logic [7:0] x_din   [2];

   always_comb
      for (int i = 0; i < 2; i++)
         x_din[i] = (!x_cen[i] && !x_oen[i]) ? (x_saddr[i][7:0] ^ 8'h5A) : 8'h00;

   cram_ctrl #(.WAIT_CYC(1)) u_w1 (
      .CLK(CLK), .RESETn(RESETn),
      .VID_REQ(x_vreq[0]), .VID_ADDR(x_vaddr[0]), .VID_ACK(x_vack[0]), .VID_DATA(x_vdata[0]),
      .CPU_REQ(1'b0), .CPU_WE(1'b0), .CPU_ADDR(9'h000), .CPU_WDATA(8'h00),
      .CPU_ACK(x_cack[0]), .CPU_RDATA(x_crd[0]),
      .SRAM_ADDR(x_saddr[0]), .SRAM_CEn(x_cen[0]), .SRAM_OEn(x_oen[0]), .SRAM_WEn(x_wen[0]),
      .SRAM_DOUT(x_dout[0]), .SRAM_DOE(x_doe[0]), .SRAM_DIN(x_din[0]), .ERR(x_err[0])
   );

   cram_ctrl #(.WAIT_CYC(8)) u_w8 (
      .CLK(CLK), .RESETn(RESETn),
      .VID_REQ(x_vreq[1]), .VID_ADDR(x_vaddr[1]), .VID_ACK(x_vack[1]), .VID_DATA(x_vdata[1]),
      .CPU_REQ(1'b0), .CPU_WE(1'b0), .CPU_ADDR(9'h000), .CPU_WDATA(8'h00),
      .CPU_ACK(x_cack[1]), .CPU_RDATA(x_crd[1]),
      .SRAM_ADDR(x_saddr[1]), .SRAM_CEn(x_cen[1]), .SRAM_OEn(x_oen[1]), .SRAM_WEn(x_wen[1]),
      .SRAM_DOUT(x_dout[1]), .SRAM_DOE(x_doe[1]), .SRAM_DIN(x_din[1]), .ERR(x_err[1])
   );

   // SRAM model: unwritten cells read addr^C3; stuck0 forces bit 0 low at 0x010
   logic [7:0] sram [512];
   bit         wr   [512];
   bit         stuck0 = 1'b0;
   logic [7:0] sram_rd;

   always @(posedge CLK)
      if (RESETn && !SRAM_CEn && !SRAM_WEn && SRAM_DOE) begin
         sram[SRAM_ADDR] <= SRAM_DOUT;
         wr[SRAM_ADDR]   <= 1'b1;
      end

   assign sram_rd  = wr[SRAM_ADDR] ? sram[SRAM_ADDR] : (SRAM_ADDR[7:0] ^ 8'hC3);
   assign SRAM_DIN = (!SRAM_CEn && !SRAM_OEn) ?
                     (sram_rd & ((stuck0 && SRAM_ADDR == 9'h010) ? 8'hFE : 8'hFF)) : 8'h00;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   int vectors = 0, miscompares = 0;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
      end
   endfunction

   // reference model
   typedef struct packed {
      logic        cpu;
      logic [7:0]  data;
      logic [31:0] cyc;
      logic        err;
   } exp_t;

   exp_t       sb[$];
   logic [7:0] ref_mem [512];
   int         starve_m = 0;
   logic [7:0] vdata_m = '0, crdata_m = '0;
   bit         err_m = 1'b0;

   task automatic predict(input bit cpu, input bit we, input logic [8:0] a,
                          input logic [7:0] wd, inout int t);
      exp_t e;
      int   lat;
      logic [7:0] rb;
      lat = (cpu && we && RB) ? 4 + 2 * W : 2 + W;
      if (cpu && we) begin
         ref_mem[a] = wd;
         rb = (stuck0 && a == 9'h010) ? (wd & 8'hFE) : wd;
         if (RB && rb != wd) err_m = 1'b1;
         e.data = crdata_m;
      end else begin
         e.data = ref_mem[a];
         if (cpu) crdata_m = e.data;
         else     vdata_m  = e.data;
      end
      e.cpu = cpu;
      e.cyc = 32'(t + lat);
      e.err = err_m;
      sb.push_back(e);
      t = t + lat + 1;
   endtask

   // one transaction per requesting port, raised together in the same cycle
   task automatic xact(input bit v, input bit c, input bit we, input logic [8:0] va,
                       input logic [8:0] ca, input logic [7:0] wd, input bit pins);
      int t, last;
      bit vd, cd, done;
      t = cyc;
      if (v && c && starve_m < 2) begin
         starve_m++;
         predict(1'b0, 1'b0, va, 8'h00, t);
         starve_m = 0;
         predict(1'b1, we, ca, wd, t);
      end else if (v && c) begin
         starve_m = 0;
         predict(1'b1, we, ca, wd, t);
         predict(1'b0, 1'b0, va, 8'h00, t);
      end else if (c) begin
         starve_m = 0;
         predict(1'b1, we, ca, wd, t);
      end else if (v) begin
         predict(1'b0, 1'b0, va, 8'h00, t);
      end
      VID_ADDR = va; CPU_WE = we; CPU_ADDR = ca; CPU_WDATA = wd;
      VID_REQ = v; CPU_REQ = c;
      vd = !v; cd = !c; done = 1'b0;
      last = (RB && we) ? 4 + 2 * W : 2 + W;
      for (int k = 0; k < 60 && !done; k++) begin
         @(negedge CLK);
         if (pins && k <= last) begin
            chk("pin_cen", 32'(SRAM_CEn), 32'(!(k >= 1 && k <= last)));
            chk("pin_wen", 32'(SRAM_WEn), 32'(!(k >= 2 && k <= 1 + W)));
            chk("pin_doe", 32'(SRAM_DOE), 32'(k >= 1 && k <= 2 + W));
            chk("pin_oen", 32'(SRAM_OEn), 32'(!(RB && k >= 4 + W && k <= 3 + 2 * W)));
         end
         if (VID_ACK) vd = 1'b1;
         if (CPU_ACK) cd = 1'b1;
         @(posedge CLK); #1;
         if (vd) VID_REQ = 1'b0;
         if (cd) CPU_REQ = 1'b0;
         done = vd && cd;
      end
      if (!done) begin
         chk("xact_timeout", 32'd1, 32'd0);
         VID_REQ = 1'b0; CPU_REQ = 1'b0;
      end
   endtask

   // both requests held high across n grants
   task automatic both_held(input int n, input logic [8:0] va, input logic [8:0] ca);
      int t, acks;
      t = cyc;
      for (int i = 0; i < n; i++) begin
         if (starve_m >= 2) begin
            starve_m = 0;
            predict(1'b1, 1'b0, ca, 8'h00, t);
         end else begin
            starve_m++;
            predict(1'b0, 1'b0, va, 8'h00, t);
         end
      end
      VID_ADDR = va; CPU_ADDR = ca; CPU_WE = 1'b0;
      VID_REQ = 1'b1; CPU_REQ = 1'b1;
      acks = 0;
      for (int k = 0; k < 300 && acks < n; k++) begin
         @(negedge CLK);
         acks += int'(VID_ACK) + int'(CPU_ACK);
         @(posedge CLK); #1;
      end
      VID_REQ = 1'b0; CPU_REQ = 1'b0;
      if (acks < n) chk("held_timeout", 32'(acks), 32'(n));
   endtask

   task automatic xvid(input int i, input int wc, input logic [8:0] a);
      int  oen;
      bit  done;
      oen = 0; done = 1'b0;
      x_vaddr[i] = a; x_vreq[i] = 1'b1;
      for (int k = 0; k < 20 && !done; k++) begin
         @(negedge CLK);
         if (!x_oen[i]) oen++;
         if (x_vack[i]) begin
            done = 1'b1;
            chk($sformatf("w%0d_ack_cycle", wc), 32'(k), 32'(2 + wc));
            chk($sformatf("w%0d_vid_data", wc), 32'(x_vdata[i]), 32'(a[7:0] ^ 8'h5A));
         end
         @(posedge CLK); #1;
         if (done) x_vreq[i] = 1'b0;
      end
      if (!done) begin
         chk($sformatf("w%0d_timeout", wc), 32'd1, 32'd0);
         x_vreq[i] = 1'b0;
      end
      chk($sformatf("w%0d_oen_width", wc), 32'(oen), 32'(wc));
   endtask

   // monitor: scoreboard pops on ACK, plus strobe-window protocol rules
   initial begin
      exp_t e;
      int   oen_run, wen_run;
      logic p_wen, p_doe, p_cen;
      logic [8:0] p_addr;
      oen_run = 0; wen_run = 0; p_wen = 1'b1; p_doe = 1'b0; p_cen = 1'b1; p_addr = '0;
      forever begin
         @(negedge CLK);
         if (!RESETn) begin
            oen_run = 0; wen_run = 0; p_wen = 1'b1; p_doe = 1'b0; p_cen = 1'b1;
         end else begin
            if (VID_ACK || CPU_ACK) begin
               if (sb.size() == 0)
                  chk("ack_unexpected", {VID_ACK, CPU_ACK}, 32'd0);
               else begin
                  e = sb.pop_front();
                  chk("ack_port", 32'({VID_ACK, CPU_ACK}), e.cpu ? 32'd1 : 32'd2);
                  chk("ack_cycle", 32'(cyc), e.cyc);
                  if (e.cpu) chk("cpu_rdata", 32'(CPU_RDATA), 32'(e.data));
                  else       chk("vid_data", 32'(VID_DATA), 32'(e.data));
                  chk("err", 32'(ERR), 32'(e.err));
               end
            end
            if (!SRAM_OEn) chk("read_no_doe", 32'(SRAM_DOE), 32'd0);
            if (!SRAM_WEn) chk("wen_window", 32'(SRAM_DOE && !SRAM_CEn), 32'd1);
            if (!SRAM_WEn && p_wen) chk("doe_setup", 32'(p_doe), 32'd1);
            if (SRAM_WEn && !p_wen) chk("doe_hold", 32'(SRAM_DOE && !SRAM_CEn), 32'd1);
            if (!SRAM_CEn && !p_cen) chk("addr_stable", 32'(SRAM_ADDR), 32'(p_addr));
            if (!SRAM_OEn) oen_run++;
            else if (oen_run != 0) begin chk("oen_width", 32'(oen_run), 32'(W)); oen_run = 0; end
            if (!SRAM_WEn) wen_run++;
            else if (wen_run != 0) begin chk("wen_width", 32'(wen_run), 32'(W)); wen_run = 0; end
            p_wen = SRAM_WEn; p_doe = SRAM_DOE; p_cen = SRAM_CEn; p_addr = SRAM_ADDR;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [8:0] ra, rc;
      int         kind;
      for (int i = 0; i < 512; i++) ref_mem[i] = 8'(i) ^ 8'hC3;
      x_vaddr[0] = '0; x_vaddr[1] = '0;

      for (int i = 0; i < 5; i++) begin
         @(negedge CLK);
         chk("reset_pins", {SRAM_CEn, SRAM_OEn, SRAM_WEn, SRAM_DOE, VID_ACK, CPU_ACK, ERR}, 32'h70);
      end
      @(posedge CLK); #1 RESETn = 1'b1;
      @(negedge CLK);
      chk("post_reset_pins", {SRAM_CEn, SRAM_OEn, SRAM_WEn, SRAM_DOE, VID_ACK, CPU_ACK, ERR}, 32'h70);
      chk("post_reset_data", {SRAM_ADDR, SRAM_DOUT, VID_DATA, CPU_RDATA}, 32'h0);
      @(posedge CLK); #1;

      xact(1'b0, 1'b1, 1'b1, 9'h000, 9'h1A5, 8'h3C, 1'b1);
      xact(1'b0, 1'b1, 1'b0, 9'h000, 9'h1A5, 8'h00, 1'b0);
      both_held(6, 9'h033, 9'h1A5);

      for (int r = 0; r < 40; r++) begin
         kind = $urandom_range(0, 2);
         ra = 9'($urandom_range(0, 31));
         rc = 9'($urandom_range(0, 31));
         xact(kind != 1, kind != 0, 1'($urandom_range(0, 1)), ra, rc, 8'($urandom), 1'b0);
         if ($urandom_range(0, 1) == 1) begin repeat ($urandom_range(1, 2)) @(posedge CLK); #1; end
      end

      // reset in the middle of a write strobe
      CPU_WE = 1'b1; CPU_ADDR = 9'h0F0; CPU_WDATA = 8'hA7; CPU_REQ = 1'b1;
      repeat (2) @(posedge CLK); #1;
      chk("wen_before_reset", 32'(SRAM_WEn), 32'd0);
      RESETn = 1'b0;
      #1;
      chk("wen_async_reset", {SRAM_CEn, SRAM_WEn, SRAM_DOE}, 32'h6);
      CPU_REQ = 1'b0;
      starve_m = 0; vdata_m = '0; crdata_m = '0; err_m = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         chk("reset_no_ack", {VID_ACK, CPU_ACK}, 32'h0);
      end
      @(posedge CLK); #1 RESETn = 1'b1;
      @(negedge CLK);
      chk("idle_after_reset", {SRAM_CEn, SRAM_OEn, SRAM_WEn, CPU_ACK}, 32'hE);
      @(posedge CLK); #1;
      xact(1'b0, 1'b1, 1'b1, 9'h000, 9'h0F0, 8'hA7, 1'b1);
      xact(1'b1, 1'b1, 1'b0, 9'h0F0, 9'h0F0, 8'h00, 1'b0);

      xvid(0, 1, 9'h0A7);
      xvid(1, 8, 9'h15C);

      stuck0 = 1'b1;
      xact(1'b0, 1'b1, 1'b1, 9'h000, 9'h010, 8'h01, 1'b1);
      stuck0 = 1'b0;
      repeat (3) @(negedge CLK);
      chk("err_sticky", 32'(ERR), 32'(RB));
      @(posedge CLK); #1;
      xact(1'b1, 1'b0, 1'b0, 9'h011, 9'h000, 8'h00, 1'b0);

      repeat (4) @(negedge CLK);
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
